// File: rtl/sound_vol_env.sv
// ---------------------------------------------------------------------------
// sound_vol_env
// Volume envelope generator for the square and noise sound channels.
// Produces the 4-bit target volume that the channel mix stage gates with
// enable/modulate. The volume steps up or down on the 64 Hz envelope tick at
// the period latched from NRx2 when the channel is triggered.
//
// Optional feature macro: SOUND_ENV_ZOMBIE_EN
//   When defined, adds the nrx2_wr port. An NRx2 write while the channel is
//   running modifies the volume immediately ("zombie mode") and relatches the
//   direction and period.
//
// Ports:
//   clk                  in   system clock, rising edge
//   rst_n                in   synchronous active-low reset
//   clk_vol_env          in   one-cycle envelope tick (64 Hz)
//   start                in   one-cycle channel trigger
//   initial_volume[3:0]  in   NRx2[7:4]
//   envelope_increasing  in   NRx2[3], 1 = up
//   num_envelope_sweeps  in   NRx2[2:0], sweep period, 0 = envelope off
//   nrx2_wr              in   NRx2 write strobe (SOUND_ENV_ZOMBIE_EN only)
//   target_vol[3:0]      out  current envelope volume (registered)
//   env_active           out  envelope still stepping (registered)
// ---------------------------------------------------------------------------
module sound_vol_env #(
    parameter int VOL_W = 4,
    parameter int PER_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clk_vol_env,
    input  logic               start,
    input  logic [VOL_W-1:0]   initial_volume,
    input  logic               envelope_increasing,
    input  logic [PER_W-1:0]   num_envelope_sweeps,
`ifdef SOUND_ENV_ZOMBIE_EN
    input  logic               nrx2_wr,
`endif
    output logic [VOL_W-1:0]   target_vol,
    output logic               env_active
);

    localparam logic [VOL_W-1:0] VOL_MAX = {VOL_W{1'b1}};
    localparam logic [VOL_W-1:0] VOL_MIN = {VOL_W{1'b0}};

    logic [VOL_W-1:0] r_vol;
    logic             r_act;
    logic [PER_W-1:0] r_timer;
    logic             r_dir;
    logic [PER_W-1:0] r_per;

    logic [VOL_W-1:0] w_vol_n;
    logic             w_act_n;
    logic [PER_W-1:0] w_timer_n;
    logic             w_dir_n;
    logic [PER_W-1:0] w_per_n;

`ifdef SOUND_ENV_ZOMBIE_EN
    // Volume after an NRx2 write to a running channel, modulo 16: a stopped
    // envelope with zero period gains 1, a decreasing one gains 2, and a
    // direction flip mirrors the result (16 - v).
    function automatic logic [VOL_W-1:0] zombie_vol(
        input logic [VOL_W-1:0] v_in,
        input logic [PER_W-1:0] per,
        input logic             act,
        input logic             dir,
        input logic             new_dir
    );
        logic [VOL_W-1:0] v;
        v = v_in;
        if ((per == {PER_W{1'b0}}) && !act) begin
            v = v + {{(VOL_W-1){1'b0}}, 1'b1};
        end else if (!dir) begin
            v = v + {{(VOL_W-2){1'b0}}, 2'b10};
        end else begin
            v = v;
        end
        if (new_dir != dir) begin
            v = VOL_MIN - v;
        end else begin
            v = v;
        end
        return v;
    endfunction
`endif

    // Next-state logic: start > NRx2 write (optional) > tick.
    always_comb begin
        w_vol_n   = r_vol;
        w_act_n   = r_act;
        w_timer_n = r_timer;
        w_dir_n   = r_dir;
        w_per_n   = r_per;
        if (start) begin
            w_vol_n   = initial_volume;
            w_dir_n   = envelope_increasing;
            w_per_n   = num_envelope_sweeps;
            w_timer_n = num_envelope_sweeps;
            w_act_n   = (num_envelope_sweeps != {PER_W{1'b0}});
`ifdef SOUND_ENV_ZOMBIE_EN
        end else if (nrx2_wr) begin
            w_vol_n = zombie_vol(r_vol, r_per, r_act, r_dir, envelope_increasing);
            w_dir_n = envelope_increasing;
            w_per_n = num_envelope_sweeps;
`endif
        end else if (clk_vol_env && r_act) begin
            if (r_timer > {{(PER_W-1){1'b0}}, 1'b1}) begin
                w_timer_n = r_timer - {{(PER_W-1){1'b0}}, 1'b1};
            end else begin
                w_timer_n = r_per;
                if (r_dir) begin
                    if (r_vol != VOL_MAX) begin
                        w_vol_n = r_vol + {{(VOL_W-1){1'b0}}, 1'b1};
                        // Stop at the same edge the step lands on the ceiling.
                        w_act_n = (r_vol != (VOL_MAX - {{(VOL_W-1){1'b0}}, 1'b1}));
                    end else begin
                        w_act_n = 1'b0;
                    end
                end else begin
                    if (r_vol != VOL_MIN) begin
                        w_vol_n = r_vol - {{(VOL_W-1){1'b0}}, 1'b1};
                        // Stop at the same edge the step lands on the floor.
                        w_act_n = (r_vol != {{(VOL_W-1){1'b0}}, 1'b1});
                    end else begin
                        w_act_n = 1'b0;
                    end
                end
            end
        end else begin
            w_vol_n = r_vol;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vol   <= {VOL_W{1'b0}};
            r_act   <= 1'b0;
            r_timer <= {PER_W{1'b0}};
            r_dir   <= 1'b0;
            r_per   <= {PER_W{1'b0}};
        end else begin
            r_vol   <= w_vol_n;
            r_act   <= w_act_n;
            r_timer <= w_timer_n;
            r_dir   <= w_dir_n;
            r_per   <= w_per_n;
        end
    end

    assign target_vol = r_vol;
    assign env_active = r_act;

endmodule

// File: tb/tb_sound_vol_env.sv
module tb_sound_vol_env;

    logic       clk;
    logic       rst_n;
    logic       clk_vol_env;
    logic       start;
    logic [3:0] initial_volume;
    logic       envelope_increasing;
    logic [2:0] num_envelope_sweeps;
    logic       nrx2_wr;
    logic [3:0] target_vol;
    logic       env_active;

    sound_vol_env dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .clk_vol_env         (clk_vol_env),
        .start               (start),
        .initial_volume      (initial_volume),
        .envelope_increasing (envelope_increasing),
        .num_envelope_sweeps (num_envelope_sweeps),
`ifdef SOUND_ENV_ZOMBIE_EN
        .nrx2_wr             (nrx2_wr),
`endif
        .target_vol          (target_vol),
        .env_active          (env_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rstn;
        logic       st;
        logic       tick;
        logic       wr;
        logic [3:0] init;
        logic       dir;
        logic [2:0] per;
        logic [3:0] exp_vol;
        logic       exp_act;
        string      name;
    } vec_t;

    typedef struct {
        logic [3:0] vol;
        logic       act;
        string      name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic vec_t mk(input logic rs, input logic s, input logic t, input logic w,
                                input logic [3:0] i, input logic d, input logic [2:0] p,
                                input logic [3:0] ev, input logic ea, input string nm);
        vec_t v;
        v.rstn = rs; v.st = s; v.tick = t; v.wr = w; v.init = i; v.dir = d; v.per = p;
        v.exp_vol = ev; v.exp_act = ea; v.name = nm;
        return v;
    endfunction

    // Drive one vector for one cycle, push expectation, compare after the edge.
    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        rst_n = v.rstn; start = v.st; clk_vol_env = v.tick; nrx2_wr = v.wr;
        initial_volume = v.init; envelope_increasing = v.dir; num_envelope_sweeps = v.per;
        e.vol = v.exp_vol; e.act = v.exp_act; e.name = v.name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        n_checks++;
        if (target_vol !== e.vol) begin
            n_errors++;
            $display("FAIL %s target_vol: got %0d expected %0d", e.name, target_vol, e.vol);
        end
        n_checks++;
        if (env_active !== e.act) begin
            n_errors++;
            $display("FAIL %s env_active: got %0b expected %0b", e.name, env_active, e.act);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; clk_vol_env = 1'b0; nrx2_wr = 1'b0;
        initial_volume = 4'd0; envelope_increasing = 1'b0; num_envelope_sweeps = 3'd0;

        //           rst   st    tick  wr    init   dir   per   vol    act
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 4'd9,  1'b1, 3'd3, 4'd0,  1'b0, "rst_a"));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 4'd9,  1'b1, 3'd3, 4'd0,  1'b0, "rst_b"));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd10, 1'b0, 3'd2, 4'd10, 1'b1, "dn_start"));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 4'd10, 1'b0, 3'd2, 4'd10, 1'b1, "dn_t1"));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 4'd10, 1'b0, 3'd2, 4'd9,  1'b1, "dn_t2"));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 4'd10, 1'b0, 3'd2, 4'd9,  1'b1, "dn_t3"));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 4'd10, 1'b0, 3'd2, 4'd8,  1'b1, "dn_t4"));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd3,  1'b1, 3'd7, 4'd8,  1'b1, "idle"));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 4'd3,  1'b1, 3'd7, 4'd8,  1'b1, "latch_t1"));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 4'd3,  1'b1, 3'd7, 4'd7,  1'b1, "latch_t2"));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd13, 1'b1, 3'd1, 4'd13, 1'b1, "up_start"));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 4'd13, 1'b1, 3'd1, 4'd14, 1'b1, "up_t1"));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 4'd13, 1'b1, 3'd1, 4'd15, 1'b0, "up_t2"));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 4'd13, 1'b1, 3'd1, 4'd15, 1'b0, "up_t3"));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd7,  1'b0, 3'd0, 4'd7,  1'b0, "off_start"));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 4'd7, 1'b0, 3'd0, 4'd7, 1'b0, "off_tick"));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 4'd5,  1'b0, 3'd1, 4'd5,  1'b1, "st_tick"));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 4'd5,  1'b0, 3'd1, 4'd4,  1'b1, "st_tick_next"));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd1,  1'b0, 3'd1, 4'd1,  1'b1, "floor_start"));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 4'd1,  1'b0, 3'd1, 4'd0,  1'b0, "floor_t1"));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 4'd1,  1'b0, 3'd1, 4'd0,  1'b0, "floor_t2"));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd6,  1'b0, 3'd3, 4'd6,  1'b1, "z_start"));
`ifdef SOUND_ENV_ZOMBIE_EN
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 4'd6,  1'b1, 3'd3, 4'd8,  1'b1, "z_wr"));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 4'd6,  1'b1, 3'd3, 4'd8,  1'b1, "z_tick"));
`else
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 4'd6,  1'b1, 3'd3, 4'd6,  1'b1, "z_wr"));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 4'd6,  1'b1, 3'd3, 4'd6,  1'b1, "z_tick"));
`endif
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 4'd11, 1'b0, 3'd2, 4'd11, 1'b1, "st_over_wr"));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 4'd11, 1'b0, 3'd2, 4'd0,  1'b0, "rst_mid"));

        foreach (vecs[i]) apply(vecs[i]);

        // Hand sequence: a long run down from 15 at period 1 on back-to-back
        // ticks must reach 0 after exactly 15 steps and then hold.
        apply(mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd15, 1'b0, 3'd1, 4'd15, 1'b1, "run_start"));
        for (int k = 1; k <= 16; k++) begin
            logic [3:0] ev;
            ev = (k >= 15) ? 4'd0 : 4'(15 - k);
            apply(mk(1'b1, 1'b0, 1'b1, 1'b0, 4'd15, 1'b0, 3'd1, ev, (k < 15), "run_tick"));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
